regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 5, register address width.
REQ-002 SHALL have parameter DATA_W, 32, register data width.
REQ-003 SHALL have parameter NREGS, 32, number of registers swept by clear; NREGS = 2**ADDR_W.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr_start  input  1  single-cycle request to re-run the clear sweep.
REQ-007 SHALL have ports a_valid input 1, a_rd input ADDR_W, a_data input DATA_W  requester A (ALU writeback).
REQ-008 SHALL have port a_ready  output  1  A write accepted this cycle.
REQ-009 SHALL have ports b_valid input 1, b_rd input ADDR_W, b_data input DATA_W  requester B (load writeback).
REQ-010 SHALL have port b_ready  output  1  B write accepted this cycle.
REQ-011 SHALL have ports rf_regwr output 1, rf_rd output ADDR_W, rf_data output DATA_W  registered register-file write port.
REQ-012 SHALL have port busy  output  1  clear sweep in progress.

Function
REQ-013 SHALL implement two states: CLEAR and RUN.
REQ-014 In CLEAR, SHALL write 0 to address cnt each cycle, cnt stepping 0..NREGS-1, then enter RUN the cycle after cnt = NREGS-1 is issued; sweep lasts exactly NREGS cycles.
REQ-015 In CLEAR, a_ready and b_ready SHALL be 0 and busy SHALL be 1.
REQ-016 In RUN, clr_start = 1 SHALL move to CLEAR with cnt = 0 next cycle; that cycle a_ready = b_ready = 0 (clear wins over simultaneous valid).
REQ-017 clr_start during CLEAR SHALL be ignored (sweep not restarted).
REQ-018 In RUN with only one valid, that requester SHALL get ready = 1 combinationally the same cycle.
REQ-019 In RUN with both valid, grant SHALL go to the requester not granted most recently (round-robin); exactly one ready asserted.
REQ-020 Round-robin pointer SHALL update only on a completed handshake (valid & ready); idle cycles leave it unchanged.
REQ-021 An accepted write SHALL appear on rf_regwr/rf_rd/rf_data exactly one cycle after the handshake (latency 1).
REQ-022 An accepted write with rd = 0 SHALL be acknowledged (ready = 1) but SHALL produce rf_regwr = 0 (r0 hard-wired zero); clear sweep does write address 0.
REQ-023 When no write is issued, rf_regwr SHALL be 0; rf_rd/rf_data hold last value.
REQ-024 Requester holding valid without ready SHALL be allowed to hold rd/data stable; block SHALL not latch unaccepted requests.
REQ-025 cnt SHALL be ADDR_W+1 bits wide, no wrap beyond NREGS-1.

Reset
REQ-026 On rst_n = 0, SHALL asynchronously set state = CLEAR, cnt = 0, rf_regwr = 0, rf_rd = 0, rf_data = 0, pointer favouring A; busy = 1.
REQ-027 Reset asserted mid-sweep or mid-traffic SHALL restart the sweep from address 0 after rst_n rises; no partial write emitted.
REQ-028 First clear write (address 0) SHALL appear on the rf port on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package SHALL hold state typedef (CLEAR, RUN), ADDR_W/DATA_W/NREGS defaults.
REQ-030 Round-robin two-way grant logic SHALL be sub-module rr_arb2 (inputs req[1:0], handshake; output gnt[1:0]).
REQ-031 Top SHALL contain state machine, clear counter and output register stage only.

Verification
REQ-032 Reset release -> 32 cycles of rf_regwr = 1, rf_rd 0..31, rf_data 0, busy = 1; then busy = 0, readies enabled.
REQ-033 RUN, a_valid only, a_rd = 5, a_data = 7 -> a_ready = 1 same cycle; next cycle rf_regwr = 1, rf_rd = 5, rf_data = 7.
REQ-034 RUN, both valid 4 cycles (A rd=3 data=10, B rd=4 data=20), pointer at A -> grants A,B,A,B; rf port shows 3/10, 4/20, 3/10, 4/20.
REQ-035 RUN, b_valid, b_rd = 0, b_data = 99 -> b_ready = 1, next cycle rf_regwr = 0.
REQ-036 RUN, clr_start with a_valid same cycle -> a_ready = 0, sweep 0..31 follows; clr_start at sweep cycle 10 -> ignored, sweep ends at 31.
REQ-037 rst_n low at sweep cycle 15 -> outputs zero immediately; after release sweep restarts at address 0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and default sizes for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned NREGS_DEF  = 32;

    // CLEAR sweeps zeros into every register; RUN arbitrates writeback traffic.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant. The priority pointer moves only on a completed handshake.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       handshake,
    output logic [1:0] gnt
);

    // 1 = requester B has priority on the next contended cycle.
    logic prio_b_q;
    logic prio_b_d;

    // Grant selection and next pointer value.
    always_comb begin
        gnt      = 2'b00;
        prio_b_d = prio_b_q;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_b_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (handshake) begin
            prio_b_d = gnt[0];
        end
    end

    // Pointer register; reset favours requester A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_b_q <= 1'b0;
        end else begin
            prio_b_q <= prio_b_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: clears all registers after reset or on request,
// then merges ALU (A) and load (B) writebacks onto one registered write port.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_regwr,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_data,
    output logic              busy
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    logic              rf_regwr_q;
    logic [ADDR_W-1:0] rf_rd_q;
    logic [DATA_W-1:0] rf_data_q;

    logic              issue_wr;
    logic [ADDR_W-1:0] issue_rd;
    logic [DATA_W-1:0] issue_data;

    logic [1:0]        gnt;
    logic              handshake;

    assign handshake = (a_valid & a_ready) | (b_valid & b_ready);

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({b_valid, a_valid}),
        .handshake (handshake),
        .gnt       (gnt)
    );

    // Next state, clear counter, readies and the write to be registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_ready    = 1'b0;
        b_ready    = 1'b0;
        busy       = 1'b0;
        issue_wr   = 1'b0;
        issue_rd   = '0;
        issue_data = '0;
        case (state_q)
            CLEAR: begin
                busy     = 1'b1;
                issue_wr = 1'b1;
                issue_rd = cnt_q[ADDR_W-1:0];
                if (cnt_q == CNT_W'(NREGS - 1)) begin
                    state_d = RUN;
                    cnt_d   = CNT_W'(NREGS);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (clr_start) begin
                    // Clear request wins over any pending writeback this cycle.
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    a_ready = gnt[0];
                    b_ready = gnt[1];
                    if (gnt[0]) begin
                        issue_wr   = (a_rd != '0);
                        issue_rd   = a_rd;
                        issue_data = a_data;
                    end else if (gnt[1]) begin
                        issue_wr   = (b_rd != '0);
                        issue_rd   = b_rd;
                        issue_data = b_data;
                    end
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State and clear-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register-file write port; address/data hold when nothing is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_regwr_q <= 1'b0;
            rf_rd_q    <= '0;
            rf_data_q  <= '0;
        end else begin
            rf_regwr_q <= issue_wr;
            if (issue_wr) begin
                rf_rd_q   <= issue_rd;
                rf_data_q <= issue_data;
            end
        end
    end

    assign rf_regwr = rf_regwr_q;
    assign rf_rd    = rf_rd_q;
    assign rf_data  = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected rf writes are queued as stimulus
// is driven and popped whenever the write port fires.
module tb_regfile_wb_arbiter;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              clr_start;
    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_regwr;
    logic [ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0] rf_data;
    logic              busy;

    wr_t exp_q[$];
    int  n_checks;
    int  n_fail;

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_start (clr_start),
        .a_valid   (a_valid),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_regwr  (rf_regwr),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port monitor, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_regwr !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check_eq("rf_spurious_wr", 64'(rf_regwr), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check_eq("rf_regwr", 64'(rf_regwr), 64'd1);
                check_eq("rf_rd", 64'(rf_rd), 64'(e.rd));
                check_eq("rf_data", 64'(rf_data), 64'(e.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int rd, input int data);
        wr_t e;
        e.rd   = ADDR_W'(rd);
        e.data = DATA_W'(data);
        exp_q.push_back(e);
    endtask

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) push_wr(i, 0);
    endtask

    // Walk a sweep that started at the previous edge; readies stay low until RUN.
    task automatic run_sweep(input string tag, input int pulse_at);
        for (int j = 1; j <= NREGS; j++) begin
            step();
            clr_start = (j == pulse_at);
            #1;
            if (j < NREGS) begin
                check_eq({tag, "_busy"}, 64'(busy), 64'd1);
                check_eq({tag, "_a_ready_low"}, 64'(a_ready), 64'd0);
                check_eq({tag, "_b_ready_low"}, 64'(b_ready), 64'd0);
            end else begin
                check_eq({tag, "_busy_done"}, 64'(busy), 64'd0);
            end
            if (j == NREGS - 1) begin
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic exp_a;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clr_start = 1'b0;
        a_valid   = 1'b0;
        a_rd      = '0;
        a_data    = '0;
        b_valid   = 1'b0;
        b_rd      = '0;
        b_data    = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_regwr", 64'(rf_regwr), 64'd0);
        check_eq("rst_rd", 64'(rf_rd), 64'd0);
        check_eq("rst_data", 64'(rf_data), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd1);

        // Power-up sweep with both requesters pending; nothing may be accepted.
        @(negedge clk);
        #1;
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd2; b_data = 32'h22;
        #1;
        check_eq("sweep0_a_ready", 64'(a_ready), 64'd0);
        push_sweep(NREGS);
        rst_n = 1'b1;
        run_sweep("sweep0", 0);

        // Single requester A.
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'd7;
        #1;
        check_eq("a_only_a_ready", 64'(a_ready), 64'd1);
        check_eq("a_only_b_ready", 64'(b_ready), 64'd0);
        push_wr(5, 7);
        step();
        a_valid = 1'b0;

        // B writes r0: acknowledged, no rf write.
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'd99;
        #1;
        check_eq("r0_b_ready", 64'(b_ready), 64'd1);
        step();
        b_valid = 1'b0;
        #1;
        check_eq("r0_no_regwr", 64'(rf_regwr), 64'd0);

        // Contention: pointer favours A, grants alternate A,B,A,B.
        for (int i = 0; i < 4; i++) begin
            step();
            a_valid = 1'b1; a_rd = 5'd3; a_data = 32'd10;
            b_valid = 1'b1; b_rd = 5'd4; b_data = 32'd20;
            exp_a = ((i % 2) == 0);
            #1;
            check_eq("rr_a_ready", 64'(a_ready), 64'(exp_a));
            check_eq("rr_b_ready", 64'(b_ready), 64'(!exp_a));
            if (exp_a) push_wr(3, 10);
            else       push_wr(4, 20);
        end
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;

        // Idle cycles leave the pointer on A.
        repeat (3) step();
        a_valid = 1'b1; a_rd = 5'd6; a_data = 32'h66;
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h77;
        #1;
        check_eq("idle_keep_a", 64'(a_ready), 64'd1);
        check_eq("idle_keep_b", 64'(b_ready), 64'd0);
        push_wr(6, 32'h66);
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;

        // Clear beats a simultaneous valid; a second clear mid-sweep is ignored.
        step();
        a_valid = 1'b1; a_rd = 5'd9; a_data = 32'd55;
        clr_start = 1'b1;
        #1;
        check_eq("clr_a_ready", 64'(a_ready), 64'd0);
        push_sweep(NREGS);
        step();
        clr_start = 1'b0;
        a_valid   = 1'b0;
        #1;
        check_eq("clr_busy", 64'(busy), 64'd1);
        run_sweep("sweep1", 10);

        // Reset during sweep at address 15: outputs clear, sweep restarts at 0.
        step();
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        push_sweep(15);
        for (int j = 1; j <= 15; j++) step();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_regwr", 64'(rf_regwr), 64'd0);
        check_eq("midrst_rd", 64'(rf_rd), 64'd0);
        check_eq("midrst_data", 64'(rf_data), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        push_sweep(NREGS);
        rst_n = 1'b1;
        run_sweep("sweep2", 0);

        repeat (3) step();
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
